stepper_multi_sequencer: RTL

//  N_CH-channel step/dir stepper sequencer with a selectable drive mode per channel: wave, full-step,

---
 rtl/stepper_multi_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/stepper_multi_sequencer.sv
// Multi-channel step/dir stepper sequencer: synchronises step/dir pins, enforces a minimum
// step spacing, tracks a signed position and drives each channel's coils from an 8-entry phase table.
module stepper_multi_sequencer #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned POS_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_GAP     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_CH-1:0]       en_i,
    input  logic [N_CH-1:0]       step_in_i,
    input  logic [N_CH-1:0]       dir_in_i,
    input  logic [2*N_CH-1:0]     mode_i,
    input  logic                  err_clr_i,
    output logic [4*N_CH-1:0]     coil_out_o,
    output logic [POS_W*N_CH-1:0] position_o,
    output logic [N_CH-1:0]       step_err_o
);
    localparam int unsigned GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
    // MIN_GAP of 0 or 1 never blocks a step, so the counter simply stays at zero.
    localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

    typedef enum logic [1:0] {ModeWave, ModeFull, ModeHalf, ModeHold} mode_e;

    function automatic logic [3:0] coil_table(input logic [2:0] ph);
        logic [3:0] c;
        unique case (ph)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0011;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0100;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b1000;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    // Wave lands on even phases and full on odd ones, so the stride depends on the current parity.
    function automatic logic [2:0] next_phase(input logic [2:0] ph, input mode_e md,
                                              input logic fwd);
        logic [2:0] stride;
        unique case (md)
            ModeHalf: stride = 3'd1;
            ModeWave: stride = ph[0] ? 3'd1 : 3'd2;
            ModeFull: stride = ph[0] ? 3'd2 : 3'd1;
            default:  stride = 3'd0;
        endcase
        return fwd ? ph + stride : ph - stride;
    endfunction

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] step_sync_q;
        logic [SYNC_STAGES-1:0] dir_sync_q;
        logic                   step_dly_q;
        logic [2:0]             phase_q, phase_d;
        logic [POS_W-1:0]       pos_q, pos_d;
        logic [GAP_W-1:0]       gap_q, gap_d;
        logic                   err_q, err_d;
        logic [3:0]             coil_q, coil_d;
        logic                   step_ev, fwd, active, accept, reject;
        mode_e                  mode;

        assign mode    = mode_e'(mode_i[2*i +: 2]);
        assign step_ev = step_sync_q[SYNC_STAGES-1] & ~step_dly_q;
        assign fwd     = dir_sync_q[SYNC_STAGES-1];
        assign active  = step_ev & en_i[i] & (mode != ModeHold);
        assign accept  = active & (gap_q == '0);
        assign reject  = active & (gap_q != '0);

        always_comb begin
            phase_d = phase_q;
            pos_d   = pos_q;
            gap_d   = gap_q;
            if (gap_q != '0) begin
                gap_d = gap_q - GAP_W'(1);
            end
            if (accept) begin
                phase_d = next_phase(phase_q, mode, fwd);
                pos_d   = fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                gap_d   = GAP_LOAD;
            end
            err_d  = (err_q & ~err_clr_i) | reject;
            coil_d = en_i[i] ? coil_table(phase_d) : 4'b0000;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                step_sync_q <= '0;
                dir_sync_q  <= '0;
                step_dly_q  <= 1'b0;
                phase_q     <= '0;
                pos_q       <= '0;
                gap_q       <= '0;
                err_q       <= 1'b0;
                coil_q      <= '0;
            end else begin
                step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_in_i[i]};
                dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_in_i[i]};
                step_dly_q  <= step_sync_q[SYNC_STAGES-1];
                phase_q     <= phase_d;
                pos_q       <= pos_d;
                gap_q       <= gap_d;
                err_q       <= err_d;
                coil_q      <= coil_d;
            end
        end

        assign coil_out_o[4*i +: 4]         = coil_q;
        assign position_o[POS_W*i +: POS_W] = pos_q;
        assign step_err_o[i]                = err_q;
    end
endmodule
